// File: rtl/frame_sequencer.sv
// frame_sequencer: sequences one display frame between the 16x16 grid logic
// and the LED streaming controller.
//   clock, reset      : system clock, synchronous active-high reset
//   run               : enables the periodic frame tick
//   step_req          : manual step, rising edge triggers one frame
//   grid_in[255:0]    : grid state (bit n+16*c = row n, column c)
//   led_done          : LED controller finished handshake
//   grid_enable       : one-cycle game-step pulse to the grid logic
//   led_start         : one-cycle start pulse to the LED controller
//   frame_out[255:0]  : latched grid snapshot for the LED controller
//   busy              : sequencer is not idle
//   overrun, timeout  : sticky error flags
//   frame_count[15:0] : completed frames, wrapping
module frame_sequencer #(
   parameter int unsigned TICK_DIV      = 1000,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned DONE_TIMEOUT  = 4096
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         run,
   input  logic         step_req,
   input  logic [255:0] grid_in,
   input  logic         led_done,
   output logic         grid_enable,
   output logic         led_start,
   output logic [255:0] frame_out,
   output logic         busy,
   output logic         overrun,
   output logic         timeout,
   output logic [15:0]  frame_count
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned DW = $clog2(DONE_TIMEOUT);

   typedef enum logic [1:0] {IDLE, STEP, SETTLE, WAIT} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tick_cnt;
   logic [SW-1:0]   settle_cnt, settle_n;
   logic [DW-1:0]   done_cnt, done_n;
   logic            pending, pending_n;
   logic            step_q;
   logic            grid_enable_n, led_start_n, busy_n, overrun_n, timeout_n;
   logic [255:0]    frame_n;
   logic [15:0]     frame_count_n;

   logic tick_c, step_edge_c, trigger_c;

   assign tick_c      = run && (tick_cnt == TW'(TICK_DIV - 1));
   assign step_edge_c = step_req & ~step_q;
   assign trigger_c   = tick_c | step_edge_c;

   // Free-running frame tick, parked at zero while run is low
   always_ff @(posedge clock) begin
      if (reset || !run || tick_c) tick_cnt <= '0;
      else                         tick_cnt <= tick_cnt + TW'(1);
   end

   // Previous step_req sample for edge detection
   always_ff @(posedge clock) begin
      if (reset) step_q <= 1'b0;
      else       step_q <= step_req;
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         done_cnt    <= '0;
         pending     <= 1'b0;
         grid_enable <= 1'b0;
         led_start   <= 1'b0;
         frame_out   <= '0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout     <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_n;
         settle_cnt  <= settle_n;
         done_cnt    <= done_n;
         pending     <= pending_n;
         grid_enable <= grid_enable_n;
         led_start   <= led_start_n;
         frame_out   <= frame_n;
         busy        <= busy_n;
         overrun     <= overrun_n;
         timeout     <= timeout_n;
         frame_count <= frame_count_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n       = state;
      settle_n      = settle_cnt;
      done_n        = done_cnt;
      pending_n     = pending;
      grid_enable_n = 1'b0;
      led_start_n   = 1'b0;
      frame_n       = frame_out;
      overrun_n     = overrun;
      timeout_n     = timeout;
      frame_count_n = frame_count;

      case (state)
         IDLE: begin
            if (trigger_c || pending) begin
               state_n       = STEP;
               grid_enable_n = 1'b1;
               pending_n     = 1'b0;
            end
         end
         STEP: begin
            state_n  = SETTLE;
            settle_n = SW'(SETTLE_CYCLES - 1);
         end
         SETTLE: begin
            if (settle_cnt == '0) begin
               state_n     = WAIT;
               frame_n     = grid_in;
               led_start_n = 1'b1;
               done_n      = '0;
            end else begin
               settle_n = settle_cnt - SW'(1);
            end
         end
         WAIT: begin
            // led_start marks the first WAIT cycle, where led_done is ignored
            if (led_start) begin
               done_n = done_cnt + DW'(1);
            end else if (led_done) begin
               state_n       = IDLE;
               frame_count_n = frame_count + 16'd1;
            end else if (done_cnt == DW'(DONE_TIMEOUT - 1)) begin
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else begin
               done_n = done_cnt + DW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Queue at most one frame; a further trigger is dropped and flagged
      if (state != IDLE && trigger_c) begin
         if (!pending) pending_n = 1'b1;
         else          overrun_n = 1'b1;
      end

      busy_n = (state_n != IDLE);
   end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Sequences one display frame for the grid/LED path: generates the game-step pulse to the grid logic, waits for the grid to settle, and latches a 256-bit snapshot. It then starts the LED streaming controller and waits for its `finished` handshake. It sits between the 16×16 grid logic and the LED controller, replacing ad-hoc start/enable sequencing in the top level. Frames come from a periodic tick while `run` is high, or from a manual step on the rising edge of `step_req`.

## Interface
- `TICK_DIV`, 1000: clock cycles between automatic ticks while `run`=1 (≥2).
- `SETTLE_CYCLES`, 1: cycles waited after `grid_enable` before sampling `grid_in` (≥1).
- `DONE_TIMEOUT`, 4096: max cycles in WAIT before abandoning the frame (≥2).

- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  level; enables the periodic tick.
- `step_req`  in  1  manual step; rising edge (internally registered) triggers one frame.
- `grid_in`  in  256  grid state from the grid logic; bit n+16*c = row n, column c.
- `led_done`  in  1  LED controller `finished`.
- `grid_enable`  out  1  one-cycle step pulse to the grid logic.
- `led_start`  out  1  one-cycle start pulse to the LED controller.
- `frame_out`  out  256  latched snapshot driven to the LED controller.
- `busy`  out  1  high whenever state ≠ IDLE.
- `overrun`  out  1  sticky; a trigger was dropped.
- `timeout`  out  1  sticky; `led_done` never arrived within `DONE_TIMEOUT`.
- `frame_count`  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- Reset values: state IDLE; all outputs 0, including `frame_out`, the stickies and `frame_count`. Tick counter, settle counter, timeout counter, pending flag and step-edge register are also 0.
- Tick counter:
  - While `run`=1, counts 0..TICK_DIV-1 and produces `tick` when at TICK_DIV-1, then wraps to 0.
  - While `run`=0, it is held at 0.
- Trigger is `tick` OR the rising edge of `step_req`. A simultaneous tick and step count as one trigger.
- States: IDLE → STEP → SETTLE → WAIT → IDLE.
  - IDLE: on a trigger or with pending=1, go to STEP. Pending is cleared on that transition.
  - STEP: `grid_enable`=1 for exactly this cycle. Go to SETTLE and load the settle counter.
  - SETTLE: stays SETTLE_CYCLES cycles. On the last cycle, `frame_out` ← `grid_in`, `led_start` is set to 1 and the state moves to WAIT.
  - WAIT:
    - `led_start` is high only during its first cycle, and `led_done` is ignored in that cycle.
    - Afterwards, `led_done`=1 increments `frame_count` and returns to IDLE.
    - If the timeout counter reaches DONE_TIMEOUT-1 first, set `timeout`, return to IDLE and do not increment `frame_count`.
- Trigger while not IDLE:
  - If pending=0, set pending.
  - If pending=1, set `overrun`; pending stays 1, so at most one frame is queued.
- A frame is never aborted by `run` falling. `run` only gates new ticks.
- Stickies clear only on `reset`.

## Timing
- Trigger sampled at edge k in IDLE:
  - `grid_enable` is high in cycle k+1.
  - SETTLE occupies cycles k+2..k+1+S, where S = SETTLE_CYCLES.
  - `led_start` is high, and `frame_out` is valid, from cycle k+2+S.
- `frame_out` holds stable from the latch until the next latch. The LED controller may read it at any time.
- `led_done` is first honored in cycle k+3+S. The `frame_count` update and `busy` falling are visible the cycle after `led_done` is sampled.
- A pending frame starts from IDLE, which is one cycle after WAIT exits. Back-to-back frames are therefore separated by exactly one IDLE cycle.
- `reset` in any state returns everything to reset values on the next edge. It overrides a simultaneous trigger or `led_done`.
- `step_req` held high yields one frame only. It must go low for at least one sampled cycle before re-arming.

## Test plan
- Reset, then `step_req` 0→1 with S=1 and `grid_in`=0xA5 pattern:
  - `grid_enable` high in exactly one cycle (cycle 1 after the sample) and `led_start` in cycle 3.
  - `frame_out`=pattern and `busy`=1.
  - `led_done` pulse at cycle 6 → `frame_count`=1 and `busy`=0 at cycle 7.
- `run`=1, TICK_DIV=8, `led_done` returned 2 cycles after each `led_start`: `grid_enable` pulses every 8 cycles, `frame_count` increments per frame, `overrun`=0.
- Two step edges during one WAIT and a third edge with `led_done` held off: exactly one queued frame starts one cycle after WAIT exits, and `overrun`=1.
- `led_done` stuck 0 with DONE_TIMEOUT=16: `timeout`=1 after 16 WAIT cycles, return to IDLE, `frame_count` unchanged. Next frame completes normally with `timeout` still 1.
- `led_done` already high during the `led_start` cycle, then low: no completion, so it times out. Separately, a tick and step edge in the same IDLE cycle → one frame, no pending.
- `reset` asserted mid-SETTLE and mid-WAIT: all outputs 0 the next cycle. A later `led_done` has no effect.
